// File: rtl/tff.sv
// rtl/tff.sv - vectorised toggle flip-flop with synchronous active-low reset
module tff #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q
);

    // Power-up value matches the reset value so Q is defined before any reset edge.
    logic [WIDTH-1:0] r_q = RESET_VALUE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= r_q ^ T;
        end
    end

    assign Q = r_q;

endmodule

// File: tb/tb_tff.sv
// tb/tb_tff.sv - directed scoreboard bench for tff (scalar and 4-bit vector)
module tb_tff;

    logic       clk;
    logic       rst1;
    logic       t1;
    logic       q1;
    logic       rst4;
    logic [3:0] t4;
    logic [3:0] q4;

    int total = 0;
    int bad   = 0;
    int highs = 0;

    logic [3:0] sb_exp[$];
    logic [3:0] exp_v;

    tff #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .T     (t1),
        .Q     (q1)
    );

    tff #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_dut4 (
        .clk   (clk),
        .reset (rst4),
        .T     (t4),
        .Q     (q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic exp);
        total++;
        assert (q1 === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, q1, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] exp);
        total++;
        assert (q4 === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, q4, exp);
        end
    endtask

    // Drive at the falling edge, push expectation, check 1 ns after the rising edge, return to falling edge.
    task automatic step1(input string tag, input logic r, input logic t, input logic exp);
        rst1 = r;
        t1   = t;
        sb_exp.push_back({3'b000, exp});
        @(posedge clk);
        #1;
        exp_v = sb_exp.pop_front();
        check1(tag, exp_v[0]);
        #4;
    endtask

    task automatic step4(input string tag, input logic r, input logic [3:0] t, input logic [3:0] exp);
        rst4 = r;
        t4   = t;
        sb_exp.push_back(exp);
        @(posedge clk);
        #1;
        exp_v = sb_exp.pop_front();
        check4(tag, exp_v);
        #4;
    endtask

    initial begin
        rst1 = 1'b0;
        t1   = 1'b1;
        rst4 = 1'b1;
        t4   = 4'b0000;

        #1;
        check1("powerup_q1", 1'b0);
        check4("powerup_q4", 4'b1010);
        #1;
        rst1 = 1'b1;

        // T inverts every 10 ns starting high; edges at 5,15,25,35,45 ns.
        sb_exp.push_back(4'd1);
        sb_exp.push_back(4'd1);
        sb_exp.push_back(4'd0);
        sb_exp.push_back(4'd0);
        sb_exp.push_back(4'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            exp_v = sb_exp.pop_front();
            check1($sformatf("powerup_edge%0d", k), exp_v[0]);
            #4;
            t1 = ~t1;
        end

        // Mid-cycle reset assertion must not affect Q until the next edge.
        rst1 = 1'b0;
        t1   = 1'b1;
        #1;
        check1("sync_reset_midcycle", 1'b1);
        #4;
        @(negedge clk);
        step1("sync_reset_edge", 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step1($sformatf("reset_hold%0d", k), 1'b0, k[0], 1'b0);
        end

        step1("reset_priority", 1'b0, 1'b1, 1'b0);
        step1("reset_release", 1'b1, 1'b1, 1'b1);

        for (int k = 0; k < 8; k++) begin
            step1($sformatf("hold%0d", k), 1'b1, 1'b0, 1'b1);
            check1($sformatf("hold_mid%0d", k), 1'b1);
        end

        step1("div_clear", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step1($sformatf("div2_%0d", k), 1'b1, 1'b1, (k % 2 == 0) ? 1'b1 : 1'b0);
            if (q1 === 1'b1) highs++;
        end
        total++;
        assert (highs == 8) else begin
            bad++;
            $error("FAIL div2_highs observed=%0d expected=%0d", highs, 8);
        end

        step4("vec_reset", 1'b0, 4'b1111, 4'b1010);
        step4("vec_t0110", 1'b1, 4'b0110, 4'b1100);
        step4("vec_t1111", 1'b1, 4'b1111, 4'b0011);
        step4("vec_hold", 1'b1, 4'b0000, 4'b0011);
        step4("vec_rearm", 1'b0, 4'b0101, 4'b1010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
